// File: rtl/sdram_req_sched.sv
// sdram_req_sched: latches requests from four SDRAM clients, arbitrates with fixed
// priority plus M68K anti-starvation, and sequences start pulses, grant and done.
module sdram_req_sched #(
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 64,
    parameter int CW           = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] en,
    input  logic       sdram_ready,
    output logic       sdram_rd_pulse,
    output logic       sdram_wr_pulse,
    output logic       sdram_rd_type,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic [3:0] pending,
    output logic       timeout_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      pending_q, pending_d, grant_q, grant_d, avail, win;
    logic [CW-1:0]   tmo_q, tmo_d, starve_q, starve_d;
    logic            err_q, err_d;

    assign avail = pending_q & en;
    // A starved M68K jumps the queue; otherwise the lowest index wins.
    assign win = (starve_q >= CW'(STARVE_LIMIT) && avail[3]) ? 4'b1000 : avail & (~avail + 4'd1);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        starve_d  = (pending_q[3] && !(state_q == ISSUE && grant_q[3]) && starve_q != '1)
                    ? starve_q + CW'(1) : starve_q;
        case (state_q)
            IDLE: begin
                pending_d = pending_q & en;
                if (sdram_ready && avail != 4'd0) begin
                    pending_d = pending_d & ~win;
                    grant_d   = win;
                    state_d   = ISSUE;
                    if (win[3]) starve_d = '0;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW, WAIT_HIGH: begin
                tmo_d = tmo_q + CW'(1);
                if (tmo_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (state_q == WAIT_LOW && !sdram_ready) begin
                    state_d = WAIT_HIGH;
                end else if (state_q == WAIT_HIGH && sdram_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // New requests land after consumption so a same-cycle request is kept.
        pending_d = pending_d | req;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            tmo_q     <= '0;
            starve_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            tmo_q     <= tmo_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
        end
    end

    assign sdram_wr_pulse = state_q == ISSUE && grant_q[0];
    assign sdram_rd_pulse = state_q == ISSUE && !grant_q[0];
    assign sdram_rd_type  = grant_q[1];
    assign grant          = grant_q;
    assign done           = state_q == DONE ? grant_q : 4'd0;
    assign pending        = pending_q;
    assign timeout_err    = err_q;
endmodule

// File: tb/tb_sdram_req_sched.sv
// tb_sdram_req_sched: scenario tasks with a grant scoreboard and a simple controller model.
module tb_sdram_req_sched;
    localparam int TIMEOUT      = 255;
    localparam int STARVE_LIMIT = 64;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       sdram_ready = 1'b1;
    logic [3:0] req = 4'd0;
    logic [3:0] en = 4'hF;
    logic       rd_pulse, wr_pulse, rd_type, timeout_err;
    logic [3:0] grant, done, pending;

    int         pass_cnt = 0;
    int         total = 0;
    int         done_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] cur_exp = 4'd0;
    bit         sb_en = 1'b1;
    bit         ctl_auto = 1'b0;

    sdram_req_sched #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT), .CW(8)) dut (
        .clk_sys(clk_sys), .reset(reset), .req(req), .en(en), .sdram_ready(sdram_ready),
        .sdram_rd_pulse(rd_pulse), .sdram_wr_pulse(wr_pulse), .sdram_rd_type(rd_type),
        .grant(grant), .done(done), .pending(pending), .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_cnt, total);
        $fatal(1);
    end

    task automatic monitor;
        forever begin
            @(negedge clk_sys);
            if ((rd_pulse || wr_pulse) && sb_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_pulse: unexpected pulse rd=%b wr=%b grant=%b, required none", rd_pulse, wr_pulse, grant);
                end else begin
                    cur_exp = exp_q.pop_front();
                    if ({grant, wr_pulse, rd_pulse, rd_type} !== {cur_exp, cur_exp[0], !cur_exp[0], cur_exp[1]})
                        $display("FAIL sb_issue: grant=%b wr=%b rd=%b type=%b, required grant=%b wr=%b rd=%b type=%b",
                                 grant, wr_pulse, rd_pulse, rd_type, cur_exp, cur_exp[0], !cur_exp[0], cur_exp[1]);
                    else pass_cnt++;
                end
            end
            if (done != 4'd0) begin
                done_cnt++;
                if (sb_en) begin
                    total++;
                    if (done !== cur_exp) $display("FAIL sb_done: done=%b required %b", done, cur_exp);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic ctl_model;
        int lowcnt = 0;
        forever begin
            @(negedge clk_sys);
            if (ctl_auto) begin
                if (rd_pulse || wr_pulse) begin
                    lowcnt = 2;
                    sdram_ready = 1'b0;
                end else if (lowcnt > 0) begin
                    lowcnt--;
                    if (lowcnt == 0) sdram_ready = 1'b1;
                end
            end
        end
    endtask

    task automatic pulse_req(input logic [3:0] v);
        @(negedge clk_sys) req = v;
        @(negedge clk_sys) req = 4'd0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while ((grant != 4'd0 || pending != 4'd0 || done != 4'd0) && n < budget);
        if (n >= budget) begin
            total++;
            $display("FAIL wait_idle: grant=%b pending=%b after %0d cycles, required idle", grant, pending, budget);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        total++;
        if (grant !== 4'd0) $display("FAIL reset_grant: %b required 0000", grant); else pass_cnt++;
        total++;
        if (done !== 4'd0) $display("FAIL reset_done: %b required 0000", done); else pass_cnt++;
        total++;
        if (pending !== 4'd0) $display("FAIL reset_pending: %b required 0000", pending); else pass_cnt++;
        total++;
        if ({rd_pulse, wr_pulse, timeout_err} !== 3'b000)
            $display("FAIL reset_flags: rd=%b wr=%b err=%b required 0 0 0", rd_pulse, wr_pulse, timeout_err);
        else pass_cnt++;
    endtask

    task automatic test_single;
        logic [9:0] expv;
        ctl_auto = 1'b0;
        exp_q.push_back(4'b1000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            expv = {(k >= 2 && k <= 7) ? 4'b1000 : 4'd0, k == 7 ? 4'b1000 : 4'd0, k == 2, 1'b0};
            total++;
            if ({grant, done, rd_pulse, wr_pulse} !== expv)
                $display("FAIL single_c%0d: grant/done/rd/wr=%b required %b", k, {grant, done, rd_pulse, wr_pulse}, expv);
            else pass_cnt++;
            req = (k == 0) ? 4'b1000 : 4'd0;
            sdram_ready = !(k >= 3 && k < 6);
        end
    endtask

    task automatic test_contention;
        int base = done_cnt;
        ctl_auto = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        pulse_req(4'b1111);
        wait_idle(100);
        total++;
        if (done_cnt - base != 4) $display("FAIL contention_dones: %0d required 4", done_cnt - base);
        else pass_cnt++;
    endtask

    task automatic test_disable;
        int base = done_cnt;
        en = 4'b1101;
        pulse_req(4'b0010);
        total++;
        if (pending !== 4'b0010) $display("FAIL disable_latched: pending=%b required 0010", pending); else pass_cnt++;
        @(negedge clk_sys);
        total++;
        if (pending !== 4'd0) $display("FAIL disable_dropped: pending=%b required 0000", pending); else pass_cnt++;
        repeat (5) @(negedge clk_sys);
        total++;
        if (done_cnt != base) $display("FAIL disable_no_done: dones=%0d required 0", done_cnt - base); else pass_cnt++;
        en = 4'hF;
        exp_q.push_back(4'b0010);
        pulse_req(4'b0010);
        wait_idle(100);
        total++;
        if (done_cnt - base != 1) $display("FAIL disable_reenable: dones=%0d required 1", done_cnt - base); else pass_cnt++;
    endtask

    task automatic test_self_rereq;
        int base = done_cnt;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        @(negedge clk_sys) req = 4'b0100;
        @(negedge clk_sys);
        @(negedge clk_sys) req = 4'd0;
        total++;
        if (pending !== 4'b0100) $display("FAIL rereq_kept: pending=%b required 0100", pending); else pass_cnt++;
        wait_idle(100);
        total++;
        if (done_cnt - base != 2) $display("FAIL rereq_twice: dones=%0d required 2", done_cnt - base); else pass_cnt++;
    endtask

    task automatic test_starve;
        bit         got = 1'b0;
        int         t3 = 1;
        logic [3:0] expg;
        sb_en = 1'b0;
        ctl_auto = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk_sys);
            if (rd_pulse || wr_pulse) begin
                expg = ((k - 1) - t3 - 1 >= STARVE_LIMIT) ? 4'b1000 : 4'b0010;
                total++;
                if (grant !== expg) $display("FAIL starve_arb_c%0d: grant=%b required %b", k - 1, grant, expg);
                else pass_cnt++;
                if (grant == 4'b1000) begin
                    got = 1'b1;
                    total++;
                    if (pending !== 4'b0010) $display("FAIL starve_crom_pending: pending=%b required 0010", pending);
                    else pass_cnt++;
                end
            end
            req = (k == 0 ? 4'b0010 : 4'd0) | (k == t3 ? 4'b1000 : 4'd0) |
                  ((rd_pulse && grant == 4'b0010) ? 4'b0010 : 4'd0);
        end
        req = 4'd0;
        if (!got) begin
            total++;
            $display("FAIL starve_granted: M68K not granted within budget, required grant 1000");
        end
        wait_idle(100);
        sb_en = 1'b1;
    endtask

    task automatic test_timeout;
        int s = -1;
        int d = -1;
        int base = done_cnt;
        ctl_auto = 1'b0;
        sdram_ready = 1'b1;
        exp_q.push_back(4'b0100);
        @(negedge clk_sys) req = 4'b0100;
        for (int k = 1; k < 400 && d < 0; k++) begin
            @(negedge clk_sys);
            req = 4'd0;
            if (rd_pulse) s = k;
            if (done != 4'd0) d = k;
        end
        total++;
        if (s < 0 || d - s != TIMEOUT + 1) $display("FAIL timeout_len: issue->done=%0d required %0d", d - s, TIMEOUT + 1);
        else pass_cnt++;
        total++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_err_set: %b required 1", timeout_err); else pass_cnt++;
        ctl_auto = 1'b1;
        exp_q.push_back(4'b1000);
        pulse_req(4'b1000);
        wait_idle(100);
        total++;
        if (done_cnt - base != 2) $display("FAIL timeout_next: dones=%0d required 2", done_cnt - base); else pass_cnt++;
        total++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_err_sticky: %b required 1", timeout_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int base;
        bit seen = 1'b0;
        ctl_auto = 1'b0;
        sdram_ready = 1'b1;
        exp_q.push_back(4'b1000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_sys);
            req = (k == 0) ? 4'b1000 : (k == 3) ? 4'b0001 : 4'd0;
            sdram_ready = !(k >= 3);
        end
        base = done_cnt;
        #1 reset = 1'b1;
        #1;
        total++;
        if (grant !== 4'd0) $display("FAIL midreset_grant: %b required 0000", grant); else pass_cnt++;
        total++;
        if (pending !== 4'd0) $display("FAIL midreset_pending: %b required 0000", pending); else pass_cnt++;
        total++;
        if ({done, timeout_err} !== 5'd0) $display("FAIL midreset_done_err: done=%b err=%b required 0000 0", done, timeout_err);
        else pass_cnt++;
        @(negedge clk_sys);
        req = 4'd0;
        reset = 1'b0;
        sdram_ready = 1'b1;
        repeat (12) begin
            @(negedge clk_sys);
            if (rd_pulse || wr_pulse || done != 4'd0) seen = 1'b1;
        end
        total++;
        if (seen || done_cnt != base) $display("FAIL midreset_quiet: activity=%b dones=%0d required none", seen, done_cnt - base);
        else pass_cnt++;
    endtask

    initial begin
        fork
            monitor();
            ctl_model();
        join_none
        test_reset();
        test_single();
        test_contention();
        test_disable();
        test_self_rereq();
        test_starve();
        test_timeout();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL sb_leftover: %0d expected grants never issued, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/sdram_req_sched.md
Name: sdram_req_sched

Overview:
- Request scheduler sitting between the video/CPU/CD-DMA requesters and the SDRAM controller.
- Latches one-cycle access requests from four sources and arbitrates them with fixed priority plus 68k anti-starvation.
- Issues read/write start pulses, holds a one-hot grant that drives the address/data mux select, and signals per-requester completion when the controller returns to ready.
- Owns only sequencing; address and data muxing are done downstream from `grant`.

Parameters:
- TIMEOUT, 255: max cycles spent in WAIT_LOW+WAIT_HIGH before an access is aborted.
- STARVE_LIMIT, 64: cycles M68K may stay pending before it is promoted to top priority.
- CW, 8: width of the timeout and starvation counters; both thresholds must be below 2^CW.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  one-cycle request pulses: [0] CD/DMA write, [1] CROM burst read, [2] SROM read, [3] M68K read.
- en  in  4  requester enable; a pending request whose enable is low at arbitration is dropped.
- sdram_ready  in  1  controller idle flag.
- sdram_rd_pulse  out  1  one-cycle read start.
- sdram_wr_pulse  out  1  one-cycle write start.
- sdram_rd_type  out  1  1 = burst read (CROM), 0 = single; valid while grant != 0.
- grant  out  4  one-hot owner, held from ISSUE through DONE.
- done  out  4  one-cycle completion pulse for the granted requester; sdram_dout is valid in this cycle.
- pending  out  4  latched outstanding requests.
- timeout_err  out  1  sticky; set on any aborted access.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state: state = IDLE; all outputs and counters are 0; timeout_err cleared.
- Reset asserted mid-access clears everything immediately; no done pulse is produced.

Request latching:
- req[i] sets pending[i] on the next edge.
- A request for an already-pending source merges into the existing pending bit; there is no queue depth.
- If req[i] arrives in the same cycle that pending[i] is consumed by a grant, pending[i] stays 1. The new request is queued behind the access just started.
- A request for the source currently running is likewise queued.

FSM states and transitions:
- IDLE:
  - Each cycle, clear pending bits with en=0.
  - If sdram_ready=1 and (pending & en) != 0, select the winner, clear its pending bit, load grant, and go to ISSUE.
- ISSUE (1 cycle):
  - Assert sdram_wr_pulse if grant[0], otherwise sdram_rd_pulse.
  - sdram_rd_type = grant[1].
  - Go to WAIT_LOW.
- WAIT_LOW: wait for sdram_ready=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for sdram_ready=1, then go to DONE.
- DONE (1 cycle): done = grant; next cycle grant = 0, state = IDLE.
- Timeout:
  - The timeout counter clears on ISSUE and increments every cycle in WAIT_LOW/WAIT_HIGH.
  - When it reaches TIMEOUT, set timeout_err and go to DONE. done still pulses so the requester never hangs.

Priority:
- Fixed order: CD write > CROM > SROM > M68K.
- Starvation counter: increments while pending[3]=1 and state != ISSUE for M68K; it saturates and clears on an M68K grant.
- When the counter is >= STARVE_LIMIT, M68K is ranked above all other sources.

Latency:
- Idle case: req at cycle t → pending at t+1 → start pulse at t+2.
- Minimum occupancy is 5 cycles: ISSUE, WAIT_LOW ≥1, WAIT_HIGH ≥1, DONE, IDLE.

Invariants:
- grant is one-hot or zero.
- rd_pulse and wr_pulse are never high together.
- At most one pulse per grant.

Test Plan:
1. Single read: req=4'b1000 at cycle 0; controller drops ready at cycle 3 and raises it at cycle 6 → rd_pulse at cycle 2; rd_type=0; grant=4'b1000 over cycles 2–7; done=4'b1000 at cycle 7.
2. Contention: req=4'b1111 in one cycle → grants in order 0001 (wr_pulse), 0010 (rd_type=1), 0100, 1000; each done pulses once.
3. Starvation, STARVE_LIMIT=64: M68K pending while CROM is re-requested every access → M68K granted at the first arbitration after its counter reaches 64, ahead of a pending CROM.
4. Disable drop: req[1] with en[1]=0 → pending[1] cleared in IDLE, no pulse, no done; a later req[1] with en[1]=1 is serviced normally.
5. Timeout: sdram_ready held 1 after ISSUE → abort after 255 WAIT cycles; timeout_err=1 and stays 1; done pulses; the next request is still serviced.
6. Edge cases:
   - req[2] during its own grant cycle → serviced twice.
   - reset asserted in WAIT_HIGH → grant, pending and done are 0 immediately; no pulse after release until a new req.
